bnat_to_bcd_seq: RTL



---
 rtl/bnat_bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bnat_to_bcd_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/bnat_bcd_pkg.sv
// Shared encodings and constants for the sequential binary-to-BCD converter.
package bnat_bcd_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Bits needed to hold a bit count of 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit adjust: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bnat_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;
endmodule

// File: rtl/bnat_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one shift-and-add-3 step per clock.
// Optional overflow flag enabled by defining BNAT_BCD_OVF_EN.
module bnat_to_bcd_seq
    import bnat_bcd_pkg::*;
#(
    parameter int N_BITS   = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_BITS-1:0]     bnat,
    output logic                  busy,
    output logic                  done,
`ifdef BNAT_BCD_OVF_EN
    output logic                  ovf,
`endif
    output logic [4*N_DIGITS-1:0] bcd
);
    localparam int CW = cnt_w(N_BITS);
    localparam int WW = 4 * N_DIGITS;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [N_BITS-1:0] shreg;
    logic [WW-1:0]   work, adj, shifted;
    logic            last;

    for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[4*d +: 4]),
            .dout (adj[4*d +: 4])
        );
    end

    assign shifted = {adj[WW-2:0], shreg[N_BITS-1]};
    assign last    = (cnt == CW'(1));
    assign busy    = (state == S_SHIFT);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = start ? S_SHIFT : S_IDLE;
            S_SHIFT:        state_nxt = last ? S_DONE : S_SHIFT;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
            work  <= '0;
            bcd   <= '0;
`ifdef BNAT_BCD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        shreg <= bnat;
                        work  <= '0;
                        cnt   <= CW'(N_BITS);
`ifdef BNAT_BCD_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    work  <= shifted;
                    shreg <= shreg << 1;
                    cnt   <= cnt - CW'(1);
                    // Result is published only once the final bit is in.
                    if (last) bcd <= shifted;
`ifdef BNAT_BCD_OVF_EN
                    if (adj[WW-1]) ovf <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
